// File: rtl/uart_pkg.sv
// Shared types and constants for the UART responder: FSM state encodings,
// bus operand type and default serial timing.
package uart_pkg;

  // Same shape as the core's load/store operand type.
  typedef logic [31:0] RV32I_OPERAND_t;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 434;
  localparam int UART_DATA_BITS            = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } UART_TX_STATE_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } UART_RX_STATE_t;

endpackage

// File: rtl/uart_rx_deser.sv
// 8N1 receive deserialiser: two-flop synchroniser on rx, start-bit glitch
// rejection, mid-bit sampling and stop-bit framing check.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  output logic [7:0]     rx_byte,
  output logic           rx_valid,
  output logic           framing_err,
  output UART_RX_STATE_t rx_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  UART_RX_STATE_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             sync1_q, sync2_q;
  logic             rxs;

  assign rxs      = sync2_q;
  assign rx_byte  = shreg_q;
  assign rx_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    rx_valid    = 1'b0;
    framing_err = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = RX_START;
      end
      RX_START: begin
        // Half a bit in: still low means a real start bit, high means a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxs ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rxs, shreg_q[7:1]};
          if (bit_idx_q == BIT_LAST) state_d = RX_STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            rx_valid = 1'b1;
            state_d  = RX_IDLE;
          end else begin
            framing_err = 1'b1;
            state_d     = RX_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_WAIT_IDLE: begin
        // A held break must return high before another start bit is accepted.
        cnt_d = '0;
        if (rxs) state_d = RX_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_responder.sv
// Memory-mapped 8N1 UART: transmit FSM driven by bus strobes, plus the
// software-visible receive flag and data registers fed by uart_rx_deser.
module uart_responder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic           clk,
  input  logic           rst,
  input  RV32I_OPERAND_t tx_wrdata,
  input  logic           tx_send,
  input  logic           rx_clear,
  input  logic           rx,
  output logic           tx,
  output RV32I_OPERAND_t rx_rddata,
  output logic           rx_flag,
  output logic           busy
);

  // Bus handshake: tx_send and rx_clear are single-cycle strobes with no
  // ready; tx_send is taken only while busy=0, and rx_valid from the
  // deserialiser is a one-cycle pulse that always overrides rx_clear.

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  UART_TX_STATE_t   tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_idx_q, tx_bit_idx_d;
  logic [7:0]       tx_shreg_q, tx_shreg_d;
  logic             tx_q, tx_d;
  logic             rx_flag_q, rx_flag_d;
  RV32I_OPERAND_t   rx_rddata_q, rx_rddata_d;

  logic [7:0]       rx_byte;
  logic             rx_valid;
  logic             rx_framing_err;
  UART_RX_STATE_t   rx_state;
  logic             unused_bits;

  uart_rx_deser #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .framing_err(rx_framing_err),
    .rx_state   (rx_state)
  );

  assign unused_bits = ^{tx_wrdata[31:8], rx_framing_err, rx_state};

  assign tx        = tx_q;
  assign busy      = (tx_state_q != TX_IDLE);
  assign rx_flag   = rx_flag_q;
  assign rx_rddata = rx_rddata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_idx_q <= '0;
      tx_shreg_q   <= '0;
      tx_q         <= 1'b1;
      rx_flag_q    <= 1'b0;
      rx_rddata_q  <= '0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_idx_q <= tx_bit_idx_d;
      tx_shreg_q   <= tx_shreg_d;
      tx_q         <= tx_d;
      rx_flag_q    <= rx_flag_d;
      rx_rddata_q  <= rx_rddata_d;
    end
  end

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q;
    tx_bit_idx_d = tx_bit_idx_q;
    tx_shreg_d   = tx_shreg_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_send) begin
          tx_shreg_d = tx_wrdata[7:0];
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d     = '0;
          tx_bit_idx_d = '0;
          tx_state_d   = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_shreg_d = {1'b0, tx_shreg_q[7:1]};
          if (tx_bit_idx_q == BIT_LAST) tx_state_d = TX_STOP;
          else tx_bit_idx_d = tx_bit_idx_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
      end
    endcase
    // Line level is registered from the next state so tx never glitches.
    tx_d = 1'b1;
    if (tx_state_d == TX_START)     tx_d = 1'b0;
    else if (tx_state_d == TX_DATA) tx_d = tx_shreg_d[0];
  end

  always_comb begin
    rx_flag_d   = rx_flag_q;
    rx_rddata_d = rx_rddata_q;
    if (rx_clear) rx_flag_d = 1'b0;
    if (rx_valid) begin
      rx_flag_d   = 1'b1;
      rx_rddata_d = {24'h0, rx_byte};
    end
  end

endmodule

// File: tb/tb_uart_responder.sv
// Randomised scoreboard bench for uart_responder at 4 clocks per bit:
// directed 8N1 scenarios plus random traffic, checked by decoupled monitors.
module tb_uart_responder;

  localparam int CPB    = 4;
  localparam int BUDGET = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tx_wrdata;
  logic        tx_send;
  logic        rx_clear;
  logic        rx;
  logic        rx_drv;
  logic        loop_en;
  logic        tx;
  logic [31:0] rx_rddata;
  logic        rx_flag;
  logic        busy;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_exp_q[$];

  assign rx = loop_en ? tx : rx_drv;

  uart_responder #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_wrdata(tx_wrdata),
    .tx_send  (tx_send),
    .rx_clear (rx_clear),
    .rx       (rx),
    .tx       (tx),
    .rx_rddata(rx_rddata),
    .rx_flag  (rx_flag),
    .busy     (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    check_cnt++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver tasks (all entered on a falling clock edge)
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  task automatic pulse_clear();
    rx_clear = 1'b1;
    @(negedge clk);
    rx_clear = 1'b0;
  endtask

  task automatic start_tx(input logic [7:0] b);
    tx_wrdata = {24'($urandom), b};
    tx_send   = 1'b1;
    @(negedge clk);
    tx_send   = 1'b0;
  endtask

  task automatic wait_tx_idle();
    for (int i = 0; i < BUDGET && busy; i++) @(negedge clk);
    check("tx_idle_timeout", busy, 1'b0);
  endtask

  // scoreboard: rx monitor, fires when a new capture becomes visible
  initial begin
    logic        prev_flag = 1'b0;
    logic [31:0] prev_data = '0;
    logic [7:0]  exp;
    forever begin
      @(negedge clk);
      if (rst && ((rx_flag && !prev_flag) || (rx_rddata !== prev_data))) begin
        if (rx_exp_q.size() == 0) begin
          check_cnt++;
          $display("FAIL rx_unexpected: got data %h flag %b with nothing expected", rx_rddata, rx_flag);
        end else begin
          exp = rx_exp_q.pop_front();
          check("rx_data", rx_rddata, {24'h0, exp});
          check("rx_flag_on_capture", rx_flag, 1'b1);
        end
      end
      prev_flag = rx_flag;
      prev_data = rx_rddata;
    end
  end

  // scoreboard: tx monitor, decodes frames from the line at mid-bit
  initial begin
    logic       tx_prev = 1'b1;
    logic [9:0] bits;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (rst && tx_prev && !tx) begin
        aborted = 1'b0;
        bits    = '0;
        for (int j = 0; j < 10; j++) begin
          repeat (j == 0 ? CPB / 2 : CPB) begin
            @(negedge clk);
            if (!rst) aborted = 1'b1;
          end
          bits[j] = tx;
        end
        if (!aborted) begin
          check("tx_start_stop", {bits[9], bits[0]}, 2'b10);
          if (tx_exp_q.size() == 0) begin
            check_cnt++;
            $display("FAIL tx_unexpected: got byte %h with nothing expected", bits[8:1]);
          end else begin
            check("tx_byte", bits[8:1], tx_exp_q.pop_front());
          end
        end
      end
      tx_prev = tx;
    end
  end

  // stimulus
  initial begin
    logic [9:0] exp_bits;
    logic [7:0] b;
    int         busy_cycles;

    rst = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
    tx_send = 1'b0; rx_clear = 1'b0; tx_wrdata = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_flag", rx_flag, 1'b0);
    check("reset_data", rx_rddata, 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_tx", tx, 1'b1);
    check("post_reset_busy", busy, 1'b0);
    check("post_reset_flag", rx_flag, 1'b0);
    check("post_reset_data", rx_rddata, 32'h0);

    // TX byte A5 with an ignored send while busy
    exp_bits = {1'b1, 8'hA5, 1'b0};
    tx_exp_q.push_back(8'hA5);
    tx_wrdata = 32'hFFFF_FFA5;
    tx_send = 1'b1;
    busy_cycles = 0;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (k == 1) tx_send = 1'b0;
      if (k == 10) begin tx_wrdata = 32'h0000_0000; tx_send = 1'b1; end
      if (k == 11) tx_send = 1'b0;
      if (busy) busy_cycles++;
      if (k <= 40) check("tx_bit", tx, exp_bits[(k - 1) / 4]);
    end
    check("tx_busy_cycles", busy_cycles, 40);
    check("tx_busy_low_after", busy, 1'b0);
    repeat (50) @(negedge clk);
    check("tx_send_while_busy_ignored", busy, 1'b0);

    // RX byte 3C then clear
    rx_exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    check("rx_3c_flag", rx_flag, 1'b1);
    check("rx_3c_data", rx_rddata, 32'h0000_003C);
    pulse_clear();
    check("rx_clear_flag", rx_flag, 1'b0);

    // glitch, framing error, then a good frame
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_no_flag", rx_flag, 1'b0);
    send_frame(8'h55, 1'b0);
    repeat (12) @(negedge clk);
    check("framing_no_flag", rx_flag, 1'b0);
    check("framing_data_kept", rx_rddata, 32'h0000_003C);
    rx_exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    repeat (3) @(negedge clk);
    check("rx_12_flag", rx_flag, 1'b1);
    check("rx_12_data", rx_rddata, 32'h0000_0012);
    pulse_clear();

    // clear colliding with capture, then overrun
    rx_exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    pulse_clear();
    check("collision_flag", rx_flag, 1'b1);
    check("collision_data", rx_rddata, 32'h0000_0081);
    rx_exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    repeat (3) @(negedge clk);
    check("overrun_flag", rx_flag, 1'b1);
    check("overrun_data", rx_rddata, 32'h0000_007E);
    pulse_clear();
    check("overrun_cleared", rx_flag, 1'b0);

    // random independent RX and TX traffic
    fork
      begin
        logic [7:0] rb;
        for (int i = 0; i < 6; i++) begin
          rb = 8'($urandom_range(0, 255));
          rx_exp_q.push_back(rb);
          send_frame(rb, 1'b1);
          repeat (3) @(negedge clk);
          check("rand_rx_data", rx_rddata, {24'h0, rb});
          pulse_clear();
          repeat ($urandom_range(0, 5)) @(negedge clk);
        end
      end
      begin
        logic [7:0] tb_b;
        for (int i = 0; i < 6; i++) begin
          tb_b = 8'($urandom_range(0, 255));
          tx_exp_q.push_back(tb_b);
          start_tx(tb_b);
          repeat ($urandom_range(1, 30)) @(negedge clk);
          tx_wrdata = $urandom;
          tx_send = 1'b1;
          @(negedge clk);
          tx_send = 1'b0;
          wait_tx_idle();
          repeat ($urandom_range(0, 5)) @(negedge clk);
        end
      end
    join

    // loopback
    loop_en = 1'b1;
    repeat (4) @(negedge clk);
    rx_exp_q.push_back(8'hC3);
    tx_exp_q.push_back(8'hC3);
    start_tx(8'hC3);
    wait_tx_idle();
    repeat (6) @(negedge clk);
    check("loop_flag", rx_flag, 1'b1);
    check("loop_data", rx_rddata, 32'h0000_00C3);
    pulse_clear();

    // reset in the middle of a looped-back frame
    b = 8'h5A;
    start_tx(b);
    repeat (12) @(negedge clk);
    check("midframe_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_flag", rx_flag, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_rx_flag", rx_flag, 1'b0);
    check("abort_no_rx_data", rx_rddata, 32'h0);
    check("abort_tx_idle", tx, 1'b1);

    check("rx_queue_drained", rx_exp_q.size(), 0);
    check("tx_queue_drained", tx_exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
